// File: rtl/s_serializer.sv
// Parallel-to-serial frame feeder: one ser_clr pulse, then WIDTH bits, one per clock.
// Define S_SERIALIZER_MSBFIRST_EN to emit MSB first (default is LSB first).
module s_serializer #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             abort,
    output logic             ser_out,
    output logic             ser_clr,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] idx, idx_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic             last_bit, xfer;
    logic             ser_out_d, ser_clr_d, ser_valid_d, ser_last_d, busy_d;

    // valid/ready: a word moves on a rising edge where load_valid && load_ready;
    // abort in the same cycle suppresses the capture.
    assign last_bit   = (state == SHIFT) && (idx == LAST_IDX);
    assign load_ready = !rst && ((state == IDLE) || last_bit);
    assign xfer       = load_valid && load_ready && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            shreg     <= '0;
            ser_out   <= 1'b0;
            ser_clr   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            shreg     <= shreg_nxt;
            ser_out   <= ser_out_d;
            ser_clr   <= ser_clr_d;
            ser_valid <= ser_valid_d;
            ser_last  <= ser_last_d;
            busy      <= busy_d;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        case (state)
            IDLE: begin
                if (xfer) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                    shreg_nxt = load_data;
                end
            end
            CLEAR: begin
                state_nxt = abort ? IDLE : SHIFT;
                idx_nxt   = '0;
            end
            SHIFT: begin
                if (abort) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else if (idx == LAST_IDX) begin
                    // Chaining straight into CLEAR keeps back-to-back frames gap-free.
                    state_nxt = xfer ? CLEAR : IDLE;
                    idx_nxt   = '0;
                    if (xfer) shreg_nxt = load_data;
                end else begin
                    idx_nxt = idx + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered, so they are decoded from the next state.
    always_comb begin
        ser_clr_d   = (state_nxt == CLEAR);
        ser_valid_d = (state_nxt == SHIFT);
        ser_last_d  = (state_nxt == SHIFT) && (idx_nxt == LAST_IDX);
        busy_d      = (state_nxt != IDLE);
        ser_out_d   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ser_valid_d && (idx_nxt == CNT_W'(i))) begin
`ifdef S_SERIALIZER_MSBFIRST_EN
                ser_out_d = shreg_nxt[WIDTH-1-i];
`else
                ser_out_d = shreg_nxt[i];
`endif
            end
        end
    end

endmodule

// File: doc/s_serializer.md
Name: s_serializer

Overview:
Parallel-to-serial frame feeder that sits directly upstream of the s_majority serial majority detector. It accepts a WIDTH-bit word over a valid/ready handshake. It emits a one-cycle frame-clear pulse for the downstream detector's clear input, then shifts the word out one bit per clock. Used so the detector sees a clean, framed bit stream without testbench-style sequencing.

Parameters:
WIDTH, 10, bits per frame (>=1)
CNT_W, 4, bit-index counter width; 2**CNT_W >= WIDTH required

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
load_data  input  WIDTH  word to serialize; sampled only on handshake
load_valid  input  1  word available
load_ready  output  1  serializer can accept a word this cycle
abort  input  1  synchronous frame abort
ser_out  output  1  serial data bit to detector `in`
ser_clr  output  1  one-cycle frame-clear pulse to detector clear input
ser_valid  output  1  ser_out carries a valid bit
ser_last  output  1  ser_out is final bit of frame
busy  output  1  frame in progress (CLEAR or SHIFT)

Behaviour:
- All outputs are registered, except load_ready, which is decoded from state and index.
- Reset (async, rst=1): state=IDLE, shift reg=0, idx=0, ser_out=0, ser_clr=0, ser_valid=0, ser_last=0, busy=0. load_ready=0 while rst=1 and 1 after release.
- Handshake: a transfer occurs on a rising edge with load_valid=1 and load_ready=1. load_data is captured into the shift register. Later changes to load_data are ignored.
- load_ready=1 in IDLE, and in SHIFT when idx=WIDTH-1 (last-bit cycle). It is 0 otherwise.
- States:
  - IDLE: ser_* outputs low. On transfer go to CLEAR.
  - CLEAR: exactly one cycle with ser_clr=1, ser_valid=0, busy=1. Next state is SHIFT with idx=0.
  - SHIFT: ser_valid=1, ser_out=word[idx] (LSB first by default), ser_last=1 when idx=WIDTH-1, busy=1. idx increments each cycle.
  - Leaving SHIFT after the last bit: go to CLEAR if a transfer occurred in that cycle, else IDLE.
- Latency: transfer at edge N, ser_clr high for cycle N..N+1, first bit valid from edge N+1 (following cycle).
- Frame length is WIDTH+1 cycles. Back-to-back frames have no idle gap.
- WIDTH=1: CLEAR, then one SHIFT cycle with ser_valid=1 and ser_last=1.
- abort=1 at an edge in CLEAR or SHIFT: go to IDLE. Next cycle all ser_* outputs are 0 and busy=0. The frame is discarded and no ser_last is produced.
- abort and a transfer in the same cycle: abort wins and the word is not captured. This applies in IDLE and in the last-bit cycle.
- abort in IDLE with no transfer: no effect.
- Reset mid-frame: immediate async return to reset values. The partial frame is lost and no ser_clr is issued.
- load_valid held high while busy and not in the last-bit cycle: no capture. The word waits.
- idx never exceeds WIDTH-1 and does not wrap within a frame.

Optional Feature:
- Macro: S_SERIALIZER_MSBFIRST_EN.
- Defined: bits are emitted MSB first, ser_out=word[WIDTH-1-idx].
- Undefined: LSB first, ser_out=word[idx].
- Handshake, timing and ser_last position are identical in both builds.

Test Plan:
1. Reset, then transfer 10'b0011000101 once -> ser_clr=1 for one cycle, then ser_out = 1,0,1,0,0,0,1,1,0,0 on 10 consecutive cycles with ser_valid=1. ser_last=1 only on the 10th bit. Then IDLE with load_ready=1.
2. load_valid held high with words 10'h3FF then 10'h000 -> frame A bits all 1. Second transfer occurs in A's last-bit cycle. ser_clr pulses on the very next cycle, then ten 0 bits. Total 22 cycles, no gap.
3. abort asserted at the 4th bit of a frame -> next cycle ser_valid=0, busy=0, ser_last never seen, load_ready=1. A new transfer then starts with ser_clr.
4. rst pulsed asynchronously (between edges) during the 6th bit -> outputs drop to 0 immediately. After release the first transfer produces a full clean frame.
5. abort=1 and load_valid=1 together in IDLE -> no capture, no ser_clr, state stays IDLE.
6. Build with S_SERIALIZER_MSBFIRST_EN and transfer 10'b0011000101 -> ser_out = 0,0,1,1,0,0,0,1,0,1, with the same timing as scenario 1.
